// File: rtl/maze_solver_if.sv
// maze_solver_if: command interface between the maze solver (master) and the
// navigation block (slave).
//   strt_hdng  master->slave  one-clock pulse, begin heading change to dsrd_hdng
//   strt_mv    master->slave  one-clock pulse, begin forward move
//   stp_lft    master->slave  level, stop the move at a left opening
//   stp_rght   master->slave  level, stop the move at a right opening
//   dsrd_hdng  master->slave  12-bit desired heading
//   mv_cmplt   slave->master  one-clock pulse, current command finished
interface maze_solver_if;
    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic [11:0] dsrd_hdng;
    logic        mv_cmplt;

    modport master (
        output strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng,
        input  mv_cmplt
    );

    modport slave (
        input  strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng,
        output mv_cmplt
    );
endinterface

// File: rtl/maze_solver.sv
// maze_solver: wall-follower command sequencer for the navigation block.
// Issues a forward move, waits for its completion, then picks the next
// direction from the IR opening flags (affinity side, forward, opposite
// side, reverse) until the goal sensor reports success.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   strt_slv, lft_affn       start pulse and wall affinity (1 = left)
//   lft_opn/rght_opn/frwrd_opn  IR opening flags, sampled in DECIDE
//   sol_cmplt                goal (magnet) detected, level
//   nav                      command interface (master side)
//   solving, solved, mv_cnt  status; mv_cnt saturates at 16'hFFFF
//   wdog_err                 sticky watchdog timeout flag
// Optional feature: define MAZE_WDOG_EN to build the per-command watchdog
// (WDOG_CYC clocks); otherwise wdog_err stays 0 and waits are unbounded.
module maze_solver #(
    parameter logic [23:0] WDOG_CYC = 24'd10_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 strt_slv,
    input  logic                 lft_affn,
    input  logic                 lft_opn,
    input  logic                 rght_opn,
    input  logic                 frwrd_opn,
    input  logic                 sol_cmplt,
    maze_solver_if.master        nav,
    output logic                 solving,
    output logic                 solved,
    output logic [15:0]          mv_cnt,
    output logic                 wdog_err
);

    typedef enum logic [2:0] {
        IDLE, ISSUE_MV, WAIT_MV, DECIDE, ISSUE_HDNG, WAIT_HDNG, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [11:0] hdng_q, hdng_d;
    logic        affn_q, affn_d;
    logic        strt_hdng_q, strt_hdng_d;
    logic        strt_mv_q, strt_mv_d;
    logic        stp_lft_q, stp_lft_d;
    logic        stp_rght_q, stp_rght_d;
    logic        solving_q, solving_d;
    logic        solved_q, solved_d;
    logic [15:0] mv_cnt_q, mv_cnt_d;
    logic        sol_seen_q, sol_seen_d;
    logic        wdog_err_q, wdog_err_d;
    logic        wdog_hit;

    function automatic logic [11:0] hdng_of(input logic [1:0] d);
        case (d)
            2'd0:    hdng_of = 12'h000;
            2'd1:    hdng_of = 12'h3FF;
            2'd2:    hdng_of = 12'h7FF;
            default: hdng_of = 12'hC00;
        endcase
    endfunction

`ifdef MAZE_WDOG_EN
    logic [23:0] wdog_cnt_q, wdog_cnt_d;
    logic        in_wait;

    // The counter restarts whenever a command pulse is on the bus, so each
    // outstanding command gets its own full budget.
    always_comb begin
        in_wait    = (state_q == WAIT_MV) || (state_q == WAIT_HDNG);
        wdog_cnt_d = 24'd0;
        wdog_hit   = 1'b0;
        if (in_wait && !(strt_mv_q || strt_hdng_q)) begin
            wdog_cnt_d = wdog_cnt_q + 24'd1;
            wdog_hit   = (wdog_cnt_d >= WDOG_CYC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdog_cnt_q <= 24'd0;
        else     wdog_cnt_q <= wdog_cnt_d;
    end
`else
    wire unused_wdog_cyc = ^WDOG_CYC;
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        logic       aff_open, opp_open;
        logic [1:0] aff_dir, opp_dir;
        logic       turn;
        logic [1:0] turn_dir;

        state_d     = state_q;
        dir_d       = dir_q;
        hdng_d      = hdng_q;
        affn_d      = affn_q;
        strt_hdng_d = 1'b0;
        strt_mv_d   = 1'b0;
        solving_d   = solving_q;
        solved_d    = solved_q;
        mv_cnt_d    = mv_cnt_q;
        sol_seen_d  = sol_seen_q;
        wdog_err_d  = wdog_err_q;

        aff_open = affn_q ? lft_opn : rght_opn;
        opp_open = affn_q ? rght_opn : lft_opn;
        aff_dir  = affn_q ? dir_q + 2'd1 : dir_q - 2'd1;
        opp_dir  = affn_q ? dir_q - 2'd1 : dir_q + 2'd1;
        turn     = 1'b0;
        turn_dir = dir_q;

        case (state_q)
            IDLE, DONE: begin
                if (strt_slv) begin
                    affn_d     = lft_affn;
                    mv_cnt_d   = 16'd0;
                    solved_d   = 1'b0;
                    solving_d  = 1'b1;
                    sol_seen_d = 1'b0;
                    wdog_err_d = 1'b0;
                    state_d    = ISSUE_MV;
                end
            end
            ISSUE_MV: begin
                strt_mv_d = 1'b1;
                if (mv_cnt_q != 16'hFFFF) mv_cnt_d = mv_cnt_q + 16'd1;
                state_d = WAIT_MV;
            end
            WAIT_MV, WAIT_HDNG: begin
                if (sol_cmplt) sol_seen_d = 1'b1;
                if (nav.mv_cmplt) begin
                    // Goal seen while the command was in flight: finish
                    // only once navigation reports the command done.
                    if (sol_seen_q || sol_cmplt) begin
                        state_d   = DONE;
                        solved_d  = 1'b1;
                        solving_d = 1'b0;
                    end else begin
                        state_d = (state_q == WAIT_MV) ? DECIDE : ISSUE_MV;
                    end
                end else if (wdog_hit) begin
                    state_d    = DONE;
                    wdog_err_d = 1'b1;
                    solving_d  = 1'b0;
                end
            end
            DECIDE: begin
                if (sol_cmplt) begin
                    state_d   = DONE;
                    solved_d  = 1'b1;
                    solving_d = 1'b0;
                end else if (aff_open) begin
                    turn = 1'b1; turn_dir = aff_dir;
                end else if (frwrd_opn) begin
                    state_d = ISSUE_MV;
                end else if (opp_open) begin
                    turn = 1'b1; turn_dir = opp_dir;
                end else begin
                    turn = 1'b1; turn_dir = dir_q + 2'd2;
                end
                if (turn) begin
                    dir_d   = turn_dir;
                    hdng_d  = hdng_of(turn_dir);
                    state_d = ISSUE_HDNG;
                end
            end
            ISSUE_HDNG: begin
                strt_hdng_d = 1'b1;
                state_d     = WAIT_HDNG;
            end
            default: state_d = IDLE;
        endcase

        stp_lft_d  = solving_d & affn_d;
        stp_rght_d = solving_d & ~affn_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= 2'd0;
            hdng_q      <= 12'h000;
            affn_q      <= 1'b0;
            strt_hdng_q <= 1'b0;
            strt_mv_q   <= 1'b0;
            stp_lft_q   <= 1'b0;
            stp_rght_q  <= 1'b0;
            solving_q   <= 1'b0;
            solved_q    <= 1'b0;
            mv_cnt_q    <= 16'd0;
            sol_seen_q  <= 1'b0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            hdng_q      <= hdng_d;
            affn_q      <= affn_d;
            strt_hdng_q <= strt_hdng_d;
            strt_mv_q   <= strt_mv_d;
            stp_lft_q   <= stp_lft_d;
            stp_rght_q  <= stp_rght_d;
            solving_q   <= solving_d;
            solved_q    <= solved_d;
            mv_cnt_q    <= mv_cnt_d;
            sol_seen_q  <= sol_seen_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign nav.strt_hdng = strt_hdng_q;
    assign nav.strt_mv   = strt_mv_q;
    assign nav.stp_lft   = stp_lft_q;
    assign nav.stp_rght  = stp_rght_q;
    assign nav.dsrd_hdng = hdng_q;
    assign solving       = solving_q;
    assign solved        = solved_q;
    assign mv_cnt        = mv_cnt_q;
    assign wdog_err      = wdog_err_q;

endmodule
